sel_decode_ctrl: RTL and testbench

- Parametrised, sequenced successor to the 3-to-8 word-select decoder in the 8x8 memory IC.
- Accepts one access request per valid/ready handshake and decodes the address to a registered one-hot word select.
- Holds the select plus a read or write strobe for a programmable number of cycles, then enforces a guard gap.
- Flags out-of-range addresses. Sits between the bus-side request logic and the memory array word lines.

---
 rtl/sel_decode_pkg.sv | 27 ++
 rtl/sel_decode_if.sv | 41 ++++
 rtl/sel_onehot_dec.sv | 23 ++
 rtl/sel_decode_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_sel_decode_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sel_decode_pkg.sv
// Shared types and helpers for the sequenced word-select controller.
// CNT_W sizes both the strobe/guard counter and the optional statistics.
package sel_decode_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      SEL,
      ERR,
      GUARD
   } state_e;

   // Bits at or above width stay clear, so unpopulated words never fire.
   function automatic logic [255:0] onehot(
      input logic [7:0] adr,
      input int         width
   );
      logic [255:0] r;
      r = '0;
      if (int'(adr) < width) begin
         r[adr] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sel_decode_if.sv
// Request/select bundle between bus-side request logic and the controller.
// master drives the request; slave returns select, strobes and status.
interface sel_decode_if #(
   parameter int ADDR_W = 3
) ();

   logic                 i_valid;
   logic                 o_ready;
   logic [ADDR_W-1:0]    i_adr;
   logic                 i_we;
   logic [2**ADDR_W-1:0] o_sel;
   logic                 o_we_strobe;
   logic                 o_re_strobe;
   logic                 o_done;
   logic                 o_err;

   modport master (
      output i_valid,
      output i_adr,
      output i_we,
      input  o_ready,
      input  o_sel,
      input  o_we_strobe,
      input  o_re_strobe,
      input  o_done,
      input  o_err
   );

   modport slave (
      input  i_valid,
      input  i_adr,
      input  i_we,
      output o_ready,
      output o_sel,
      output o_we_strobe,
      output o_re_strobe,
      output o_done,
      output o_err
   );

endinterface

// File: rtl/sel_onehot_dec.sv
// Combinational ADDR_W to 2**ADDR_W one-hot decoder with enable.
// Outputs at indices >= DEPTH are masked to zero.
module sel_onehot_dec
   import sel_decode_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 8
) (
   input  logic                 i_en,
   input  logic [ADDR_W-1:0]    i_adr,
   output logic [2**ADDR_W-1:0] o_sel
);

   localparam int SEL_W = 2**ADDR_W;

   always_comb begin
      o_sel = '0;
      if (i_en) begin
         o_sel = SEL_W'(onehot(8'(i_adr), DEPTH));
      end
   end

endmodule

// File: rtl/sel_decode_ctrl.sv
// Sequenced word-select controller: accept, strobe, guard, flag bad address.
// Define SEL_DECODE_CNT_EN to add saturating access/error counters.
module sel_decode_ctrl
   import sel_decode_pkg::*;
#(
   parameter int ADDR_W     = 3,
   parameter int DEPTH      = 8,
   parameter int STROBE_CYC = 2,
   parameter int GUARD_CYC  = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   sel_decode_if.slave      bus
`ifdef SEL_DECODE_CNT_EN
   ,
   output logic [CNT_W-1:0] o_acc_cnt,
   output logic [CNT_W-1:0] o_err_cnt
`endif
);

   localparam int SEL_W = 2**ADDR_W;
   localparam logic [CNT_W-1:0] STB_LD =
      CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] GRD_LD =
      CNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
   localparam state_e POST =
      (GUARD_CYC > 0) ? GUARD : IDLE;

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [SEL_W-1:0] sel_q;
   logic [SEL_W-1:0] sel_d;
   logic [SEL_W-1:0] dec_sel;
   logic             we_q;
   logic             we_d;
   logic             re_q;
   logic             re_d;
   logic             done_q;
   logic             done_d;
   logic             err_q;
   logic             err_d;
   logic             ready_q;
   logic             ready_d;
   logic             accept;
   logic             in_range;

   assign accept   = bus.i_valid && ready_q;
   assign in_range = int'(bus.i_adr) < DEPTH;

   sel_onehot_dec #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_dec (
      .i_en   (accept && in_range),
      .i_adr  (bus.i_adr),
      .o_sel  (dec_sel)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = '0;
      we_d    = 1'b0;
      re_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept && in_range) begin
               state_d = SEL;
               cnt_d   = STB_LD;
               sel_d   = dec_sel;
               we_d    = bus.i_we;
               re_d    = !bus.i_we;
               done_d  = (STB_LD == '0);
            end else if (accept) begin
               state_d = ERR;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end
         end
         SEL: begin
            if (cnt_q == '0) begin
               state_d = POST;
               cnt_d   = GRD_LD;
            end else begin
               cnt_d  = cnt_q - CNT_W'(1);
               sel_d  = sel_q;
               we_d   = we_q;
               re_d   = re_q;
               done_d = (cnt_q == CNT_W'(1));
            end
         end
         ERR: begin
            state_d = POST;
            cnt_d   = GRD_LD;
         end
         GUARD: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Ready is registered, so it leads the IDLE state by one decision.
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         re_q    <= re_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ready_q <= ready_d;
      end
   end

   assign bus.o_ready     = ready_q;
   assign bus.o_sel       = sel_q;
   assign bus.o_we_strobe = we_q;
   assign bus.o_re_strobe = re_q;
   assign bus.o_done      = done_q;
   assign bus.o_err       = err_q;

`ifdef SEL_DECODE_CNT_EN
   logic [CNT_W-1:0] acc_cnt_q;
   logic [CNT_W-1:0] acc_cnt_d;
   logic [CNT_W-1:0] err_cnt_q;
   logic [CNT_W-1:0] err_cnt_d;

   always_comb begin
      acc_cnt_d = acc_cnt_q;
      err_cnt_d = err_cnt_q;
      if (done_d && !err_d && acc_cnt_q != '1) begin
         acc_cnt_d = acc_cnt_q + CNT_W'(1);
      end
      if (err_d && err_cnt_q != '1) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         acc_cnt_q <= acc_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign o_acc_cnt = acc_cnt_q;
   assign o_err_cnt = err_cnt_q;
`endif

   a_sel_onehot0: assert property (
      @(posedge i_clk) disable iff (!i_rst_n)
      $onehot0(sel_q));

   a_strobe_excl: assert property (
      @(posedge i_clk) disable iff (!i_rst_n)
      !(we_q && re_q));

   a_err_done: assert property (
      @(posedge i_clk) disable iff (!i_rst_n)
      err_q |-> done_q);

endmodule

// File: tb/tb_sel_decode_ctrl.sv
// Bench for sel_decode_ctrl: three parameter sets, timeline model, literal pins.
// Counter checks are built only when SEL_DECODE_CNT_EN is defined.
module tb_sel_decode_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n [3] = '{1'b0, 1'b0, 1'b0};
   logic       v     [3] = '{1'b0, 1'b0, 1'b0};
   logic       we_i  [3] = '{1'b0, 1'b0, 1'b0};
   logic [2:0] adr   [3] = '{3'd0, 3'd0, 3'd0};

   logic [7:0] q_sel [3];
   logic       q_rdy [3];
   logic       q_wes [3];
   logic       q_res [3];
   logic       q_dn  [3];
   logic       q_er  [3];

   int p_d [3] = '{8, 6, 8};
   int p_s [3] = '{2, 2, 1};
   int p_g [3] = '{1, 1, 0};

   sel_decode_if #(.ADDR_W(3)) bif0 ();
   sel_decode_if #(.ADDR_W(3)) bif1 ();
   sel_decode_if #(.ADDR_W(3)) bif2 ();

   assign bif0.i_valid = v[0];
   assign bif0.i_adr   = adr[0];
   assign bif0.i_we    = we_i[0];
   assign bif1.i_valid = v[1];
   assign bif1.i_adr   = adr[1];
   assign bif1.i_we    = we_i[1];
   assign bif2.i_valid = v[2];
   assign bif2.i_adr   = adr[2];
   assign bif2.i_we    = we_i[2];

   assign q_sel[0] = bif0.o_sel;
   assign q_rdy[0] = bif0.o_ready;
   assign q_wes[0] = bif0.o_we_strobe;
   assign q_res[0] = bif0.o_re_strobe;
   assign q_dn[0]  = bif0.o_done;
   assign q_er[0]  = bif0.o_err;
   assign q_sel[1] = bif1.o_sel;
   assign q_rdy[1] = bif1.o_ready;
   assign q_wes[1] = bif1.o_we_strobe;
   assign q_res[1] = bif1.o_re_strobe;
   assign q_dn[1]  = bif1.o_done;
   assign q_er[1]  = bif1.o_err;
   assign q_sel[2] = bif2.o_sel;
   assign q_rdy[2] = bif2.o_ready;
   assign q_wes[2] = bif2.o_we_strobe;
   assign q_res[2] = bif2.o_re_strobe;
   assign q_dn[2]  = bif2.o_done;
   assign q_er[2]  = bif2.o_err;

`ifdef SEL_DECODE_CNT_EN
   logic [7:0] acc_c [3];
   logic [7:0] err_c [3];
`endif

   sel_decode_ctrl #(.ADDR_W(3), .DEPTH(8), .STROBE_CYC(2), .GUARD_CYC(1)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n[0]), .bus(bif0)
`ifdef SEL_DECODE_CNT_EN
      , .o_acc_cnt(acc_c[0]), .o_err_cnt(err_c[0])
`endif
   );

   sel_decode_ctrl #(.ADDR_W(3), .DEPTH(6), .STROBE_CYC(2), .GUARD_CYC(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n[1]), .bus(bif1)
`ifdef SEL_DECODE_CNT_EN
      , .o_acc_cnt(acc_c[1]), .o_err_cnt(err_c[1])
`endif
   );

   sel_decode_ctrl #(.ADDR_W(3), .DEPTH(8), .STROBE_CYC(1), .GUARD_CYC(0)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n[2]), .bus(bif2)
`ifdef SEL_DECODE_CNT_EN
      , .o_acc_cnt(acc_c[2]), .o_err_cnt(err_c[2])
`endif
   );

   // Timeline model: an accept at edge E owns the next S windows (1 if bad).
   localparam int BIG = 1 << 30;
   int         n = 0;
   int         acc_e    [3] = '{-100, -100, -100};
   int         rdy_from [3] = '{BIG, BIG, BIG};
   bit         rel_pend [3] = '{1'b1, 1'b1, 1'b1};
   logic [7:0] m_sel    [3] = '{8'h0, 8'h0, 8'h0};
   bit         m_we     [3] = '{1'b0, 1'b0, 1'b0};
   bit         m_err    [3] = '{1'b0, 1'b0, 1'b0};
   int         macc     [3] = '{0, 0, 0};

   always @(posedge clk) begin
      n = n + 1;
      for (int i = 0; i < 3; i++) begin
         if (!rst_n[i]) begin
            acc_e[i]    = -100;
            rdy_from[i] = BIG;
            rel_pend[i] = 1'b1;
         end else if (rel_pend[i]) begin
            rel_pend[i] = 1'b0;
            rdy_from[i] = n;
         end else if (v[i] && rdy_from[i] <= n - 1) begin
            acc_e[i]    = n;
            m_we[i]     = we_i[i];
            m_err[i]    = int'(adr[i]) >= p_d[i];
            m_sel[i]    = m_err[i] ? 8'h00 : (8'd1 << adr[i]);
            rdy_from[i] = n + (m_err[i] ? 1 : p_s[i]) + p_g[i];
            macc[i]     = macc[i] + 1;
         end
      end
   end

   function automatic logic [12:0] exp_out(int i);
      logic [7:0] s;
      logic       w, r, d, e, rd;
      int         k;
      s = '0; w = 0; r = 0; d = 0; e = 0; rd = 0;
      if (rst_n[i]) begin
         k = n - acc_e[i];
         if (m_err[i]) begin
            if (k == 0) begin d = 1; e = 1; end
         end else if (k >= 0 && k < p_s[i]) begin
            s = m_sel[i];
            w = m_we[i];
            r = !m_we[i];
            d = (k == p_s[i] - 1);
         end
         rd = (n >= rdy_from[i]);
      end
      return {s, w, r, d, e, rd};
   endfunction

   int nchk  = 0;
   int nfail = 0;

   task automatic chk(input string nm, input logic [15:0] got,
                      input logic [15:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic cmp_loop();
      logic [12:0] g;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            g = {q_sel[i], q_wes[i], q_res[i], q_dn[i], q_er[i], q_rdy[i]};
            chk($sformatf("model_dut%0d_edge%0d", i, n), 16'(g),
                16'(exp_out(i)));
         end
      end
   endtask

   task automatic req(input int i, input logic [2:0] a, input logic w);
      int c0;
      int t;
      c0 = macc[i];
      t  = 0;
      @(negedge clk);
      v[i] = 1'b1; adr[i] = a; we_i[i] = w;
      while (macc[i] == c0 && t < 30) begin
         @(negedge clk);
         t++;
      end
      v[i] = 1'b0;
      chk($sformatf("req_accept_dut%0d", i), 16'(t < 30), 16'd1);
   endtask

   task automatic rst_pulse(input int i);
      @(negedge clk);
      rst_n[i] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n[i] = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // {sel,we,done,rdy}: write to 5 from idle
   logic [10:0] WR [5] = '{11'h001, 11'h104, 11'h106, 11'h000, 11'h001};
   // {sel,re}: reads 0,7,3 back to back
   logic [8:0]  RD [12] = '{9'h003, 9'h003, 9'h000, 9'h000,
                            9'h101, 9'h101, 9'h000, 9'h000,
                            9'h011, 9'h011, 9'h000, 9'h000};
   // {sel,we,err,done,rdy}: 6, 7 out of range then 5 with DEPTH=6
   logic [11:0] OR [8] = '{12'h006, 12'h000, 12'h001, 12'h006,
                           12'h000, 12'h001, 12'h208, 12'h20A};
   // {sel,done,rdy}: STROBE_CYC=1, GUARD_CYC=0 stream
   logic [2:0]  SEQ [8] = '{3'd1, 3'd6, 3'd4, 3'd0, 3'd2, 3'd7, 3'd3, 3'd5};
   logic [9:0]  CR  [8] = '{10'h00A, 10'h001, 10'h042, 10'h001,
                            10'h012, 10'h001, 10'h022, 10'h001};

   initial begin
      fork
         cmp_loop();
      join_none

      repeat (2) @(negedge clk);
      chk("reset_ready", 16'(q_rdy[0]), 16'd0);
      chk("reset_sel", 16'(q_sel[0]), 16'd0);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1; rst_n[2] = 1'b1;
      v[0] = 1'b1; adr[0] = 3'd5; we_i[0] = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         chk($sformatf("write5_%0d", j),
             16'({q_sel[0], q_wes[0], q_dn[0], q_rdy[0]}), 16'(WR[j]));
         if (j == 1) v[0] = 1'b0;
      end

      v[0] = 1'b1; adr[0] = 3'd0; we_i[0] = 1'b0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         chk($sformatf("reads_%0d", j),
             16'({q_sel[0], q_res[0]}), 16'(RD[j]));
         if (j == 0) adr[0] = 3'd7;
         if (j == 4) adr[0] = 3'd3;
         if (j == 8) v[0] = 1'b0;
      end

      v[1] = 1'b1; adr[1] = 3'd6; we_i[1] = 1'b1;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         chk($sformatf("range_%0d", j),
             16'({q_sel[1], q_wes[1], q_er[1], q_dn[1], q_rdy[1]}),
             16'(OR[j]));
         if (j == 0) adr[1] = 3'd7;
         if (j == 3) adr[1] = 3'd5;
         if (j == 6) v[1] = 1'b0;
      end

      v[2] = 1'b1; adr[2] = SEQ[0]; we_i[2] = 1'b0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         chk($sformatf("s1g0_%0d", j),
             16'({q_sel[2], q_dn[2], q_rdy[2]}), 16'(CR[j]));
         if (j < 7) adr[2] = SEQ[j+1];
         else v[2] = 1'b0;
      end

      @(negedge clk);
      v[0] = 1'b1; adr[0] = 3'd2; we_i[0] = 1'b1;
      @(posedge clk);
      #1 adr[0] = 3'd6; v[0] = 1'b0;
      #1 chk("mid_sel_held", 16'(q_sel[0]), 16'h0004);
      #1 rst_n[0] = 1'b0;
      #1 chk("mid_rst_drop", 16'({q_sel[0], q_wes[0], q_dn[0]}), 16'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n[0] = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_release", 16'(q_rdy[0]), 16'd1);

      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 12; j++) begin
            req(i, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         end
      end

`ifdef SEL_DECODE_CNT_EN
      rst_pulse(1);
      chk("cnt_reset_acc", 16'(acc_c[1]), 16'd0);
      for (int j = 0; j < 300; j++) begin
         req(1, 3'(j % 6), 1'(j % 2));
      end
      for (int j = 0; j < 3; j++) begin
         req(1, 3'(6 + (j % 2)), 1'b0);
      end
      repeat (4) @(negedge clk);
      chk("acc_cnt_sat", 16'(acc_c[1]), 16'd255);
      chk("err_cnt", 16'(err_c[1]), 16'd3);
`else
      rst_pulse(1);
`endif

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
